// File: rtl/nn_pkg.sv
// Shared activation-path definitions: 10-bit activation range, MAC state encoding
// and the clamp used by every producer of activation-stage inputs.
package nn_pkg;

   localparam int ACT_W   = 10;
   localparam int ACT_MAX = 511;
   localparam int ACT_MIN = -512;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DRAIN,
      EMIT
   } state_t;

   // Callers sign-extend their value to 64 bits before clamping.
   function automatic logic [ACT_W-1:0] sat_act(input logic signed [63:0] v);
      if (v > ACT_MAX)
         return 10'h1FF;
      else if (v < ACT_MIN)
         return 10'h200;
      else
         return v[ACT_W-1:0];
   endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Pair stream in, activation result out, for one neuron MAC.
// master drives start/bias/pairs; slave is the MAC and returns result and status.
interface neuron_mac_if
   import nn_pkg::*;
#(
   parameter int DATA_W = 8
);
   logic                     start;
   logic signed [DATA_W-1:0] bias;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] x;
   logic signed [DATA_W-1:0] w;
   logic [ACT_W-1:0]         act_in;
   logic                     act_fn_en;
   logic                     busy;

   modport master (
      output start, bias, in_valid, x, w,
      input  in_ready, act_in, act_fn_en, busy
   );

   modport slave (
      input  start, bias, in_valid, x, w,
      output in_ready, act_in, act_fn_en, busy
   );
endinterface

// File: rtl/shift_sat.sv
// Combinational arithmetic right shift (floor) of a wide sum, then clamp into
// the signed 10-bit activation range.
module shift_sat
   import nn_pkg::*;
#(
   parameter int ACC_W = 19,
   parameter int SHIFT = 0
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic [ACT_W-1:0]        act
);
   logic signed [ACC_W-1:0] shifted;
   logic signed [63:0]      wide;

   assign shifted = acc >>> SHIFT;
   assign wide    = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};
   assign act     = sat_act(wide);
endmodule

// File: rtl/neuron_mac.sv
// Neuron MAC: bias + sum of N_INPUTS signed x*w products, shifted and saturated
// to a 10-bit activation with a one-cycle act_fn_en strobe.
module neuron_mac
   import nn_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int N_INPUTS = 16,
   parameter int SHIFT    = 0
) (
   input logic          clk,
   input logic          rst,
   neuron_mac_if.slave  bus
);
   localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1;
   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

   state_t                     state;
   logic signed [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]           cnt;
   logic signed [2*DATA_W-1:0] prod_q;
   logic                       prod_v;
   logic [ACT_W-1:0]           act_q;
   logic                       fn_en_q;
   logic [ACT_W-1:0]           sat_out;

   logic                       hs;
   logic signed [2*DATA_W-1:0] x_ext;
   logic signed [2*DATA_W-1:0] w_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    prod_ext;

   assign hs       = bus.in_valid && (state == ACC);
   assign x_ext    = {{DATA_W{bus.x[DATA_W-1]}}, bus.x};
   assign w_ext    = {{DATA_W{bus.w[DATA_W-1]}}, bus.w};
   assign bias_ext = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias};
   assign prod_ext = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};

   shift_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
   ) u_shift_sat (
      .acc (acc),
      .act (sat_out)
   );

   // Product is registered one cycle ahead of the add, so DRAIN absorbs the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         prod_q  <= '0;
         prod_v  <= 1'b0;
         act_q   <= '0;
         fn_en_q <= 1'b0;
      end else begin
         fn_en_q <= 1'b0;
         prod_v  <= hs;
         if (hs)
            prod_q <= x_ext * w_ext;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc   <= bias_ext;
                  cnt   <= '0;
                  state <= ACC;
               end
            end
            ACC: begin
               if (prod_v)
                  acc <= acc + prod_ext;
               if (hs) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (prod_v)
                  acc <= acc + prod_ext;
               state <= EMIT;
            end
            EMIT: begin
               act_q   <= sat_out;
               fn_en_q <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == ACC);
   assign bus.busy      = (state != IDLE);
   assign bus.act_in    = act_q;
   assign bus.act_fn_en = fn_en_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Drives two MACs (SHIFT=0 and SHIFT=2, N_INPUTS=4) with identical streams and
// compares against a plain-arithmetic reference of bias + sum, floor-divide, clamp.
module tb_neuron_mac;
   localparam int DW = 8;
   localparam int NI = 4;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   px [NI];
   int   pw [NI];
   logic [9:0] prev0;
   logic [9:0] prev2;

   neuron_mac_if #(.DATA_W(DW)) if0 ();
   neuron_mac_if #(.DATA_W(DW)) if2 ();

   neuron_mac #(.DATA_W(DW), .N_INPUTS(NI), .SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   neuron_mac #(.DATA_W(DW), .N_INPUTS(NI), .SHIFT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] ref_act(input int sum, input int sh);
      int d;
      int q;
      d = 1 << sh;
      if (sum >= 0) q = sum / d;
      else          q = -((-sum + d - 1) / d);
      if (q > 511)  q = 511;
      if (q < -512) q = -512;
      return q[9:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input int b, input logic v, input int xv, input int wv);
      if0.start = s;  if0.bias = 8'(b); if0.in_valid = v; if0.x = 8'(xv); if0.w = 8'(wv);
      if2.start = s;  if2.bias = 8'(b); if2.in_valid = v; if2.x = 8'(xv); if2.w = 8'(wv);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic rdy, input logic bsy, input logic fn);
      chk1({tag, "_ready0"}, if0.in_ready, rdy);
      chk1({tag, "_busy0"}, if0.busy, bsy);
      chk1({tag, "_fn0"}, if0.act_fn_en, fn);
      chk1({tag, "_ready2"}, if2.in_ready, rdy);
      chk1({tag, "_busy2"}, if2.busy, bsy);
      chk1({tag, "_fn2"}, if2.act_fn_en, fn);
   endtask

   // Starts from IDLE; returns in the cycle where act_fn_en should be high.
   task automatic run_eval(input string tag, input int b, input bit noisy);
      int sum;
      int g;
      logic [9:0] e0;
      logic [9:0] e2;
      sum = b;
      for (int i = 0; i < NI; i++) sum += px[i] * pw[i];
      e0 = ref_act(sum, 0);
      e2 = ref_act(sum, 2);

      drive(1'b1, b, noisy, 127, 127);
      step();
      chk_status({tag, "_start"}, 1'b1, 1'b1, 1'b0);
      chk10({tag, "_held0"}, if0.act_in, prev0);
      chk10({tag, "_held2"}, if2.act_in, prev2);

      for (int i = 0; i < NI; i++) begin
         g = noisy ? int'($urandom_range(0, 3)) : 0;
         repeat (g) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128, 1'b0,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            step();
            chk1({tag, "_gap_ready"}, if0.in_ready, 1'b1);
         end
         drive(noisy, -100, 1'b1, px[i], pw[i]);
         step();
      end

      drive(noisy, -100, noisy, 127, 127);
      chk_status({tag, "_drain"}, 1'b0, 1'b1, 1'b0);
      step();
      chk_status({tag, "_emit"}, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 0, 1'b0, 0, 0);
      chk_status({tag, "_strobe"}, 1'b0, 1'b0, 1'b1);
      chk10({tag, "_act0"}, if0.act_in, e0);
      chk10({tag, "_act2"}, if2.act_in, e2);
      prev0 = e0;
      prev2 = e2;
   endtask

   task automatic idle_check(input string tag);
      step();
      chk_status({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
      chk10({tag, "_keep0"}, if0.act_in, prev0);
   endtask

   task automatic fill(input int xv, input int wv);
      for (int i = 0; i < NI; i++) begin
         px[i] = xv;
         pw[i] = wv;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      prev0       = '0;
      prev2       = '0;
      rst         = 1'b1;
      drive(1'b0, 0, 1'b0, 0, 0);
      step();
      step();
      chk_status("reset", 1'b0, 1'b0, 1'b0);
      chk10("reset_act0", if0.act_in, 10'h000);
      chk10("reset_act2", if2.act_in, 10'h000);
      rst = 1'b0;
      step();

      fill(5, 6);
      run_eval("basic", 3, 1'b0);
      idle_check("basic");

      fill(-128, 127);
      run_eval("sat_neg", 0, 1'b0);
      fill(127, 127);
      run_eval("sat_pos", 0, 1'b0);
      idle_check("sat");

      fill(0, 0);
      run_eval("neg_floor", -5, 1'b0);
      idle_check("neg_floor");

      fill(5, 6);
      run_eval("gaps", 3, 1'b1);
      fill(2, -3);
      run_eval("b2b", -1, 1'b0);
      idle_check("b2b");

      fill(9, 9);
      drive(1'b1, 7, 1'b0, 0, 0);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 0, 1'b1, 9, 9);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 0, 1'b0, 0, 0);
      chk_status("midrst", 1'b0, 1'b0, 1'b0);
      chk10("midrst_act0", if0.act_in, 10'h000);
      chk10("midrst_act2", if2.act_in, 10'h000);
      prev0 = '0;
      prev2 = '0;
      repeat (5) begin
         step();
         chk1("midrst_nostrobe", if0.act_fn_en, 1'b0);
      end
      fill(1, 1);
      run_eval("fresh", 0, 1'b0);
      idle_check("fresh");

      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < NI; i++) begin
            px[i] = int'($urandom_range(0, 255)) - 128;
            pw[i] = int'($urandom_range(0, 255)) - 128;
         end
         if (r % 3 == 0) begin
            for (int i = 0; i < NI; i++) px[i] = px[i] / 16;
         end
         run_eval("rand", int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_check("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Multiply-accumulate front end for one neuron: accepts a stream of signed (activation, weight) pairs over a valid/ready handshake, adds a bias, and scales and saturates the sum. It presents the result to the activation stage as a 10-bit value with a one-cycle `act_fn_en` strobe. It produces exactly the `in[9:0]` / `act_fn_en` pair that the relu stage consumes.

## Interface

Parameters:
- `DATA_W`, default 8: width of signed `x`, `w`, and `bias`.
- `N_INPUTS`, default 16: number of pairs per neuron evaluation; must be ≥ 1.
- `SHIFT`, default 0: arithmetic right shift applied to the accumulator before saturation.
- `ACC_W` (localparam) = 2*DATA_W + $clog2(N_INPUTS) + 1.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin an evaluation; honoured only in IDLE.
- `bias`  in  DATA_W: signed bias, sampled on the accepted `start`.
- `in_valid`  in  1: pair valid.
- `in_ready`  out  1: pair accepted when `in_valid & in_ready` at a clock edge.
- `x`  in  DATA_W: signed activation.
- `w`  in  DATA_W: signed weight.
- `act_in`  out  10: signed two's-complement result, held until the next result.
- `act_fn_en`  out  1: one-cycle strobe; `act_in` is valid in the same cycle.
- `busy`  out  1: high in every state except IDLE.

## Operation

States and transitions:
- IDLE: `in_ready`=0. On `start`: `acc` ← sign-extended `bias`, `cnt` ← 0, go to ACC.
- ACC: `in_ready`=1.
  - Each handshake registers `prod_q` = `x*w` (full 2*DATA_W signed) and sets `prod_v`.
  - Each cycle with `prod_v`=1, `acc` += sign-extended `prod_q`.
  - `cnt` increments per handshake only; cycles with `in_valid` low do not count.
  - Handshake with `cnt`==N_INPUTS-1: go to DRAIN.
- DRAIN: `in_ready`=0. The final product is added. Go to EMIT.
- EMIT:
  - `act_in` ← sat(`acc` >>> SHIFT); `act_fn_en` ← 1 for this one registered cycle.
  - Go to IDLE.

Arithmetic:
- Shift is arithmetic, which truncates toward −∞.
- sat clamps to [−512, 511]: above 511 gives 511 (0x1FF); below −512 gives −512 (0x200).
- `ACC_W` guarantees the accumulator never overflows.

Boundary rules:
- `start` outside IDLE is ignored; bias is not resampled.
- `in_valid` outside ACC is ignored, and no product is registered.
- `N_INPUTS`=1: a single handshake goes directly from ACC to DRAIN.
- `start` in the same cycle that `act_fn_en` is high: the FSM is already in IDLE, so the start is accepted. Back-to-back evaluations are allowed.
- `rst` at any time: state IDLE, and `acc`, `cnt`, `prod_q`, `prod_v`, `act_in`, `act_fn_en` are all cleared. The partial sum is discarded and no strobe is produced.

## Timing

- Reset values: `in_ready`=0, `act_in`=0, `act_fn_en`=0, `busy`=0.
- `start` accepted at edge S: `in_ready` is high from the cycle after S.
- Final handshake at edge E0:
  - `prod_q` is captured at E0.
  - `acc` holds the final sum after E1.
  - `act_in` and `act_fn_en` are registered at E2.
  - `act_fn_en` is therefore visible in the cycle after E2 and drops the following cycle.
- Minimum evaluation: 1 (start) + N_INPUTS + 2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs, except that `in_ready` is decoded from state only.

## Structure

- Shared package `nn_pkg`:
  - `ACT_W`=10, `ACT_MAX`=511, `ACT_MIN`=−512.
  - The state enum (IDLE, ACC, DRAIN, EMIT).
  - A `sat_act` function shared with other producers of activation inputs.
- One natural sub-module, `shift_sat`: a combinational ACC_W→10 arithmetic shift plus clamp, reused by pooling blocks.
- Everything else (multiplier register, accumulator, counter, FSM) lives in `neuron_mac`.

## Test plan

All tests use DATA_W=8 and N_INPUTS=4 unless noted.

- Basic sum, SHIFT=0: bias=3, four pairs x=5, w=6, continuous valid → `act_in`=123, one `act_fn_en` pulse exactly 2 cycles after the last handshake edge, `busy` low afterwards.
- Saturation: four pairs x=−128, w=127, bias=0 → `act_in`=0x200 (−512). Four pairs x=127, w=127 → 0x1FF (511).
- Shift rounding, SHIFT=2: sum 123 → 30. Sum −5 (bias=−5, all x=0) → −2 (0x3FE).
- Backpressure/gaps: same stimulus as the basic test with `in_valid` low on random cycles, and `start`/extra `in_valid` pulses while busy → still 123, only 4 handshakes counted, exactly one strobe.
- Reset mid-operation: assert `rst` after 2 handshakes → all outputs 0 next cycle and no strobe. A fresh evaluation (bias=0, x=1, w=1 ×4) yields 4.
- Back-to-back: `start` in the `act_fn_en` cycle with a new bias=−1 and pairs x=2, w=−3 → second `act_in`=−25 (0x3E7), with the first result intact.
